// File: rtl/md5_mem_responder.sv
// Memory-side slave for the md5 core: dual-channel byte-lane word store with preload
// port, illegal-access flagging and a result FIFO fed by stores into the result region.
module md5_mem_responder #(
    parameter logic [31:0] BASE_ADDR     = 32'h40000000,
    parameter int          DEPTH_WORDS   = 128,
    parameter logic [31:0] RESULT_OFFSET = 32'h100,
    parameter int          FIFO_DEPTH    = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [1:0]                     mem_oe,
    input  logic [1:0]                     mem_we,
    input  logic [63:0]                    mem_addr,
    input  logic [63:0]                    mem_wdata,
    input  logic [11:0]                    mem_size,
    output logic [63:0]                    mem_rdata,
    output logic [1:0]                     mem_data_rdy,
    input  logic                           load_valid,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
    input  logic [31:0]                    load_data,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [$clog2(DEPTH_WORDS)-1:0] res_index,
    output logic [31:0]                    res_data,
    output logic                           err,
    output logic                           overflow
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH_WORDS);

    function automatic logic [31:0] apply_lanes(input logic [31:0] old, input logic [3:0] be,
                                                input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] size_mask(input logic [5:0] sz);
        case (sz)
            6'd8:    return 32'h0000_00FF;
            6'd16:   return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    logic [31:0] mem [DEPTH_WORDS];
    logic [AW+31:0] fifo_q [FIFO_DEPTH];

    logic [1:0]           ch_req, ch_legal, ch_wr, ch_push;
    logic [1:0][AW-1:0]   ch_idx;
    logic [1:0][3:0]      ch_be;
    logic [1:0][31:0]     ch_wd, ch_rd, ch_post;
    logic [31:0]          ld_post;

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            logic [31:0] a, off;
            logic [5:0]  sz;
            logic [1:0]  lane;
            logic        size_ok, align_ok;
            a        = mem_addr[32*c +: 32];
            sz       = mem_size[6*c +: 6];
            lane     = a[1:0];
            off      = a - BASE_ADDR;
            size_ok  = (sz == 6'd8) || (sz == 6'd16) || (sz == 6'd32);
            align_ok = !((sz == 6'd16) && a[0]) && !((sz == 6'd32) && (lane != 2'd0));
            ch_req[c]   = mem_oe[c] | mem_we[c];
            ch_legal[c] = ch_req[c] && (off < WIN_BYTES) && size_ok && align_ok
                          && !(mem_oe[c] && mem_we[c]);
            ch_idx[c]   = off[AW+1:2];
            case (sz)
                6'd8:    ch_be[c] = 4'b0001 << lane;
                6'd16:   ch_be[c] = 4'b0011 << lane;
                default: ch_be[c] = 4'b1111;
            endcase
            ch_wd[c]   = mem_wdata[32*c +: 32] << {lane, 3'b000};
            ch_wr[c]   = ch_legal[c] && mem_we[c];
            ch_push[c] = ch_wr[c] && (off >= RESULT_OFFSET);
            // Reads see the pre-write word; illegal reads return zero.
            ch_rd[c]   = (ch_legal[c] && mem_oe[c])
                         ? ((mem[ch_idx[c]] >> {lane, 3'b000}) & size_mask(sz)) : 32'd0;
        end
        // Merge order: preload, then channel 0, then channel 1.
        for (int c = 0; c < 2; c++) begin
            ch_post[c] = mem[ch_idx[c]];
            if (load_valid && (load_addr == ch_idx[c])) ch_post[c] = load_data;
            for (int k = 0; k < 2; k++)
                if (ch_wr[k] && (ch_idx[k] == ch_idx[c]))
                    ch_post[c] = apply_lanes(ch_post[c], ch_be[k], ch_wd[k]);
        end
        ld_post = load_data;
        for (int k = 0; k < 2; k++)
            if (ch_wr[k] && (ch_idx[k] == load_addr))
                ld_post = apply_lanes(ld_post, ch_be[k], ch_wd[k]);
    end

    // Store update: all writers of one word commit the same merged value.
    always_ff @(posedge clk) begin
        if (load_valid) mem[load_addr] <= ld_post;
        for (int c = 0; c < 2; c++)
            if (ch_wr[c]) mem[ch_idx[c]] <= ch_post[c];
    end

    logic [PW:0]    wr_ptr, rd_ptr, count, free, rd_nxt, slot1;
    logic           pop, acc0, acc1;
    logic [AW+31:0] first_ent;

    assign count     = wr_ptr - rd_ptr;
    assign res_valid = (count != '0);
    assign pop       = res_valid && res_ready;
    assign free      = (PW+1)'(FIFO_DEPTH) - count + (PW+1)'(pop);
    assign acc0      = ch_push[0] && (free != '0);
    assign acc1      = ch_push[1] && (free > (PW+1)'(acc0));
    assign slot1     = wr_ptr + (PW+1)'(acc0);
    assign rd_nxt    = rd_ptr + (PW+1)'(pop);
    assign first_ent = acc0 ? {ch_idx[0], ch_post[0]} : {ch_idx[1], ch_post[1]};

    always_ff @(posedge clk) begin
        if (acc0) fifo_q[wr_ptr[PW-1:0]] <= {ch_idx[0], ch_post[0]};
        if (acc1) fifo_q[slot1[PW-1:0]]  <= {ch_idx[1], ch_post[1]};
    end

    logic [63:0]    rdata_p1;
    logic [1:0]     vld_p1;
    logic [AW+31:0] head_p1;

    // Response stage: one-cycle read/ack, registered FIFO head.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            err      <= 1'b0;
            overflow <= 1'b0;
            rdata_p1 <= '0;
            vld_p1   <= '0;
            head_p1  <= '0;
        end else begin
            wr_ptr   <= wr_ptr + (PW+1)'(acc0) + (PW+1)'(acc1);
            rd_ptr   <= rd_nxt;
            err      <= err | (|(ch_req & ~ch_legal));
            overflow <= overflow | (ch_push[0] && !acc0) | (ch_push[1] && !acc1);
            rdata_p1 <= {ch_rd[1], ch_rd[0]};
            vld_p1   <= ch_req;
            if (rd_nxt != wr_ptr)   head_p1 <= fifo_q[rd_nxt[PW-1:0]];
            else if (acc0 || acc1)  head_p1 <= first_ent;
        end
    end

    assign mem_rdata    = rdata_p1;
    assign mem_data_rdy = vld_p1;
    assign res_index    = head_p1[AW+31:32];
    assign res_data     = head_p1[31:0];
endmodule

// File: tb/tb_md5_mem_responder.sv
// Bench for md5_mem_responder: directed scenarios plus random traffic, every cycle
// checked against a byte-level reference model of the store and a queue for the FIFO.
module tb_md5_mem_responder;
    localparam logic [31:0] BASE = 32'h40000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_oe, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [11:0] mem_size;
    logic [63:0] mem_rdata;
    logic [1:0]  mem_data_rdy;
    logic        load_valid;
    logic [6:0]  load_addr;
    logic [31:0] load_data;
    logic        res_valid, res_ready;
    logic [6:0]  res_index;
    logic [31:0] res_data;
    logic        err, overflow;

    md5_mem_responder dut (
        .clk(clk), .reset(reset), .mem_oe(mem_oe), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_rdata(mem_rdata), .mem_data_rdy(mem_data_rdy),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_index(res_index),
        .res_data(res_data), .err(err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] mm [128];
    logic [38:0] q [$];
    bit          m_err, m_ov;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        mem_oe = 2'b00; mem_we = 2'b00; load_valid = 1'b0;
    endtask

    task automatic set_ch(input int c, input bit o, input bit w, input logic [31:0] a,
                          input logic [5:0] s, input logic [31:0] d);
        mem_oe[c] = o; mem_we[c] = w;
        mem_addr[32*c +: 32]  = a;
        mem_size[6*c +: 6]    = s;
        mem_wdata[32*c +: 32] = d;
    endtask

    // Model one clock edge from the current inputs, then compare all outputs.
    task automatic do_cycle();
        logic [63:0] exp_rd;
        logic [1:0]  exp_rdy;
        bit          legal [2];
        bit          req [2];
        int          idx [2], lane [2], nb [2];
        logic [31:0] off [2];
        logic [31:0] a;
        int          sz;
        exp_rd = '0; exp_rdy = '0;
        for (int c = 0; c < 2; c++) begin
            a        = mem_addr[32*c +: 32];
            sz       = int'(mem_size[6*c +: 6]);
            off[c]   = a - BASE;
            req[c]   = mem_oe[c] || mem_we[c];
            legal[c] = req[c] && (off[c] < 32'd512) && (sz == 8 || sz == 16 || sz == 32)
                       && ((a % (sz / 8)) == 0) && !(mem_oe[c] && mem_we[c]);
            idx[c]   = int'(off[c] / 4);
            lane[c]  = int'(a % 4);
            nb[c]    = sz / 8;
            if (legal[c] && mem_oe[c])
                exp_rd[32*c +: 32] = 32'(((64'(mm[idx[c]]) >> (8 * lane[c])) & ((64'd1 << sz) - 1)));
            exp_rdy[c] = req[c];
        end
        if (load_valid) mm[load_addr] = load_data;
        for (int c = 0; c < 2; c++)
            if (legal[c] && mem_we[c])
                for (int b = 0; b < nb[c]; b++)
                    mm[idx[c]][8*(lane[c]+b) +: 8] = mem_wdata[32*c + 8*b +: 8];
        if (reset) begin
            q.delete(); m_err = 0; m_ov = 0; exp_rd = '0; exp_rdy = '0;
        end else begin
            if (q.size() > 0 && res_ready) void'(q.pop_front());
            for (int c = 0; c < 2; c++) begin
                if (req[c] && !legal[c]) m_err = 1;
                if (legal[c] && mem_we[c] && off[c] >= 32'h100) begin
                    if (q.size() < 8) q.push_back({7'(idx[c]), mm[idx[c]]});
                    else m_ov = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        check("rdata", mem_rdata, exp_rd);
        check("data_rdy", 64'(mem_data_rdy), 64'(exp_rdy));
        check("err", 64'(err), 64'(m_err));
        check("overflow", 64'(overflow), 64'(m_ov));
        check("res_valid", 64'(res_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check("res_index", 64'(res_index), 64'(q[0][38:32]));
            check("res_data", 64'(res_data), 64'(q[0][31:0]));
        end
    endtask

    initial begin
        logic [5:0]  s;
        logic [31:0] a;
        int          w, ln, r;
        reset = 1'b1; res_ready = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_size = '0;
        load_addr = '0; load_data = '0;
        idle();
        do_cycle();
        do_cycle();
        check("rst_rdata", mem_rdata, 64'd0);
        check("rst_rdy", 64'(mem_data_rdy), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_index", 64'(res_index), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 128; i++) begin
            load_valid = 1'b1; load_addr = 7'(i);
            load_data = (i == 0) ? 32'h00000080 : $urandom;
            do_cycle();
        end
        idle();

        set_ch(0, 1, 0, BASE, 6'd32, 32'd0);
        do_cycle();
        check("preload_read", 64'(mem_rdata[31:0]), 64'h80);
        check("preload_rdy", 64'(mem_data_rdy), 64'b01);
        check("preload_err", 64'(err), 64'd0);
        idle();

        load_valid = 1'b1; load_addr = 7'd0; load_data = 32'hAABBCCDD;
        do_cycle();
        idle();
        set_ch(0, 1, 0, BASE + 32'd1, 6'd8, 32'd0);
        set_ch(1, 1, 0, BASE + 32'd3, 6'd8, 32'd0);
        do_cycle();
        check("dual_byte_rdata", mem_rdata, 64'h000000AA_000000CC);
        check("dual_byte_rdy", 64'(mem_data_rdy), 64'b11);
        idle();

        set_ch(0, 0, 1, BASE + 32'h100, 6'd32, 32'h11111111);
        set_ch(1, 0, 1, BASE + 32'h102, 6'd16, 32'h00002222);
        do_cycle();
        idle();
        check("coll_valid", 64'(res_valid), 64'd1);
        check("coll_index", 64'(res_index), 64'd64);
        check("coll_data", 64'(res_data), 64'h22221111);
        set_ch(0, 1, 0, BASE + 32'h100, 6'd32, 32'd0);
        do_cycle();
        check("coll_readback", 64'(mem_rdata[31:0]), 64'h22221111);
        idle();
        res_ready = 1'b1;
        do_cycle();
        check("coll_second_index", 64'(res_index), 64'd64);
        check("coll_second_data", 64'(res_data), 64'h22221111);
        do_cycle();
        check("coll_drained", 64'(res_valid), 64'd0);
        res_ready = 1'b0;

        set_ch(0, 0, 1, BASE + 32'h200, 6'd32, 32'hDEADBEEF);
        do_cycle();
        check("ill_wr_rdy", 64'(mem_data_rdy), 64'b01);
        check("ill_wr_err", 64'(err), 64'd1);
        idle();
        reset = 1'b1;
        do_cycle();
        reset = 1'b0;
        set_ch(0, 1, 0, BASE + 32'd2, 6'd32, 32'd0);
        do_cycle();
        check("misalign_rdata", mem_rdata, 64'd0);
        check("misalign_err", 64'(err), 64'd1);
        idle();

        for (int k = 0; k < 9; k++) begin
            set_ch(0, 0, 1, BASE + 32'h100 + 32'(4 * k), 6'd32, 32'hC0DE0000 + 32'(k));
            do_cycle();
        end
        idle();
        check("ovf_valid", 64'(res_valid), 64'd1);
        check("ovf_flag", 64'(overflow), 64'd1);
        res_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("drain_index", 64'(res_index), 64'(64 + k));
            check("drain_data", 64'(res_data), 64'(32'hC0DE0000 + 32'(k)));
            do_cycle();
        end
        check("drain_empty", 64'(res_valid), 64'd0);
        res_ready = 1'b0;

        for (int k = 0; k < 4; k++) begin
            set_ch(0, 1, 0, BASE + 32'(4 * k), 6'd32, 32'd0);
            reset = (k == 2);
            do_cycle();
            check("burst_rdy", 64'(mem_data_rdy[0]), 64'(k != 2));
        end
        reset = 1'b0;
        idle();
        check("burst_err", 64'(err), 64'd0);
        check("burst_overflow", 64'(overflow), 64'd0);

        for (int it = 0; it < 600; it++) begin
            idle();
            reset = ($urandom_range(0, 79) == 0);
            res_ready = ($urandom_range(0, 2) != 0);
            for (int c = 0; c < 2; c++) begin
                r = $urandom_range(0, 9);
                case ($urandom_range(0, 3))
                    0: s = 6'd8;
                    1: s = 6'd16;
                    2: s = 6'd32;
                    default: s = ($urandom_range(0, 3) == 0) ? 6'(24) : 6'd32;
                endcase
                w  = $urandom_range(0, 127);
                ln = (s == 6'd8) ? $urandom_range(0, 3) : (s == 6'd16) ? 2 * $urandom_range(0, 1) : 0;
                a  = BASE + 32'(4 * w + ln);
                if ($urandom_range(0, 11) == 0) a = a ^ 32'($urandom_range(1, 3));
                if ($urandom_range(0, 15) == 0) a = BASE + 32'h200 + 32'($urandom_range(0, 255));
                if (r >= 3) set_ch(c, (r < 6) || (r == 9), (r >= 6), a, s, $urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                load_valid = 1'b1; load_addr = 7'($urandom_range(0, 127)); load_data = $urandom;
            end
            do_cycle();
        end
        reset = 1'b0;
        idle();
        do_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/md5_mem_responder.md
# md5_mem_responder

Memory-side slave for the HLS `md5` core's dual-channel memory port: answers its loads and stores from a local 128 × 32-bit word store mapped at a fixed base address. A preload port fills the input block before `start`. Every store into the result region is also pushed into a small FIFO and streamed out as (word index, word value) for the LED and logic-analyzer drivers. It replaces the ad-hoc read-data and data-ready logic in the board top.

## Interface
- `BASE_ADDR`, 32'h40000000, byte address of word 0.
- `DEPTH_WORDS`, 128, word store depth; the window is `BASE_ADDR` .. `BASE_ADDR + 4*DEPTH_WORDS - 1`.
- `RESULT_OFFSET`, 32'h100, byte offset where the result region starts; all offsets from here to the window end are result region.
- `FIFO_DEPTH`, 8, result FIFO entries; power of two.
- `clk` in 1: the single clock, shared with the `md5` core.
- `reset` in 1: synchronous, active-high.
- `mem_oe` in 2: per-channel read request; channel 0 is bit 0.
- `mem_we` in 2: per-channel write request.
- `mem_addr` in 64: channel 0 byte address in [31:0], channel 1 in [63:32].
- `mem_wdata` in 64: channel 0 write data in [31:0], channel 1 in [63:32]; data is LSB-aligned.
- `mem_size` in 12: access size in bits; channel 0 in [5:0], channel 1 in [11:6]; legal values 8, 16, 32.
- `mem_rdata` out 64: per-channel read data, LSB-aligned and zero-extended.
- `mem_data_rdy` out 2: per-channel completion pulse.
- `load_valid` in 1: preload write strobe; one word per cycle.
- `load_addr` in 7: preload word index.
- `load_data` in 32: preload word.
- `res_valid` out 1: result FIFO is not empty.
- `res_ready` in 1: pop strobe; an entry is popped when `res_valid` and `res_ready` are both high.
- `res_index` out 7: word index of the FIFO head.
- `res_data` out 32: word value of the FIFO head.
- `err` out 1: sticky; set by any illegal access.
- `overflow` out 1: sticky; set when a result push is dropped.

## Operation
- **Requests:** a request on a channel is `oe` or `we` sampled high at a rising edge.
  - `oe` and `we` both high on the same channel is illegal.
  - Each channel is handled independently; two simultaneous requests are both served in the same cycle.
- **Address decode:**
  - word index = (addr − `BASE_ADDR`)[8:2]
  - byte lane = addr[1:0]
- **Illegal access:** any of the following.
  - Address outside the window.
  - Size not 8, 16 or 32.
  - Misalignment: size 16 with addr[0] = 1, or size 32 with addr[1:0] ≠ 0.
  - `oe` and `we` both high on one channel.
- **Response to an illegal access:**
  - `err` is set.
  - A write is discarded.
  - A read returns 0.
  - `mem_data_rdy` still pulses, so the core never stalls.
- **Read:** returns the addressed bytes shifted down to bit 0, upper bits zero.
- **Write:** updates only the addressed byte lanes.
- **Same-cycle writes to the same word:**
  - Channel 0 lanes are applied first, then channel 1, so channel 1 wins on overlapping bytes.
  - A core write also beats a preload write on overlapping bytes.
- **Read during write, same word, same cycle:** the read returns the pre-write value.
- **Result capture:** every legal core write whose offset is ≥ `RESULT_OFFSET` pushes {index, full post-write word}.
  - If both channels push in one cycle, channel 0's entry goes first.
  - Both channels writing the same result word in one cycle produce two identical entries.
  - A push arriving while the FIFO is full is dropped and sets `overflow`. When two pushes arrive with one free slot, only channel 0's entry is kept.
  - A pop and a push in the same cycle on a full FIFO both succeed.
- **Preload:** `load_valid` writes `load_data` to `load_addr` and never generates a result push.
- **Reset:** clears the FIFO pointers, `err`, `overflow`, `mem_rdata` and `mem_data_rdy`. Word store contents are preserved across reset.

## Timing
- Reset values: `mem_rdata` = 0, `mem_data_rdy` = 2'b00, `res_valid` = 0, `res_index` = 0, `res_data` = 0, `err` = 0, `overflow` = 0.
- **Latency:**
  - A request sampled at edge N produces `mem_data_rdy[ch]` high for exactly the cycle after N.
  - `mem_rdata[ch]` is valid in that same cycle and returns to 0 afterwards.
- **Back-to-back:** a new request every cycle per channel gives one `mem_data_rdy` pulse per request, with no bubbles.
- **Write visibility:** a write at edge N is visible to a read sampled at edge N+1.
- **Result path:**
  - A result push at edge N raises `res_valid` in the cycle after N.
  - `res_index` and `res_data` are registered FIFO-head outputs; they are stable while `res_valid` is high and `res_ready` is low.
- **Reset mid-transaction:** a request sampled in the same cycle as `reset` gets no `mem_data_rdy` pulse. A write in that cycle still commits to the word store.
- `err` and `overflow` clear only on `reset`.

## Test plan
- **Preload and read:** preload word 0 = 32'h00000080, reset low, channel 0 32-bit read at 32'h40000000 → cycle+1: `mem_rdata[31:0]` = 32'h00000080, `mem_data_rdy` = 2'b01, `err` = 0.
- **Dual byte read:** channel 0 byte read at 32'h40000001 and channel 1 byte read at 32'h40000003, word = 32'hAABBCCDD → same cycle+1: `mem_rdata` = {32'h000000AA, 32'h000000CC}, `mem_data_rdy` = 2'b11.
- **Same-word write collision:** channel 0 writes 32'h11111111 and channel 1 writes 16'h2222 at 32'h40000102 in the same cycle → word 64 = 32'h22221111. Two FIFO entries, each {64, 32'h22221111}, popped in order.
- **Illegal accesses:**
  - Write at 32'h40000200 → `mem_data_rdy` pulses, `err` = 1, store unchanged.
  - Misaligned 32-bit read at 32'h40000002 → `mem_rdata` = 0, `err` = 1.
- **FIFO overflow:** with `res_ready` = 0, issue 9 result writes → `res_valid` = 1, the 9th is dropped, `overflow` = 1. Drain → 8 entries, in order.
- **Reset mid-burst:** 4 back-to-back reads with `reset` asserted on the 3rd → only reads 1, 2 and 4 get `mem_data_rdy`. `err` and `overflow` = 0 after reset, and previously preloaded words still read back intact.
